mux2_rr_arbiter: RTL and testbench
==================================

// Module: mux2_rr_arbiter
// PURPOSE
//  Two-input round-robin arbiter with a one-entry registered output stage.
//  Sits directly upstream of the 2:1 mux: picks which of two valid/ready
//  sources is forwarded, and drives the mux select S through port sel.
//  Fair alternation when both sources are valid; full throughput of one
//  word per cycle.
// PARAMETERS
//  WIDTH    8   data width of each input and of the output
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  in0_valid  in   1      source 0 has a word
//  in0_data   in   WIDTH  source 0 data
//  in0_ready  out  1      source 0 word accepted this cycle when valid&ready
//  in1_valid  in   1      source 1 has a word
//  in1_data   in   WIDTH  source 1 data
//  in1_ready  out  1      source 1 word accepted this cycle when valid&ready
//  out_valid  out  1      output register holds a word
//  out_data   out  WIDTH  registered output word
//  out_ready  in   1      downstream takes word when out_valid&out_ready
//  sel        out  1      source index of current out_data; drives mux S
//  last_grant out  1      round-robin pointer (index of last accepted source)
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): out_valid=0, out_data=0, sel=0,
//    last_grant=1 (so in0 wins the first tie). While rst=1,
//    in0_ready=in1_ready=0.
//  - can_accept = !out_valid | out_ready (register empty or draining).
//  - Grant (combinational): only in0_valid -> g=0; only in1_valid -> g=1;
//    both -> g=~last_grant; neither -> no grant.
//  - inN_ready = can_accept & !rst & (N==g) & inN_valid-gated grant.
//    The losing source's ready is 0. Ready never depends on its own
//    valid except through the grant.
//  - On accept (inG_valid & inG_ready) at edge: out_data<=inG_data,
//    sel<=g, out_valid<=1, last_grant<=g.
//  - No accept but out_ready&out_valid: out_valid<=0; out_data, sel and
//    last_grant hold.
//  - Stall (out_valid & !out_ready): out_data, sel and out_valid stable;
//    both in*_ready=0.
//  - Latency: input-accept edge to out_valid = 1 cycle; back-to-back
//    accept and drain in the same cycle gives 1 word/cycle.
//  - last_grant changes only on an accepted transfer; a source dropping
//    valid without being accepted does not move the pointer.
//  - Reset mid-transfer: pending output word is discarded (out_valid=0)
//    and the pointer returns to 1.
// TESTING
//  1 Reset: rst=1 for 2 clks -> out_valid=0, out_data=0, sel=0,
//    last_grant=1, both readys 0.
//  2 Single source: in0 streams 8'h01..8'h04, out_ready=1 -> out_data
//    01..04 on consecutive cycles, 1 cycle later, sel=0 throughout.
//  3 Tie: both valid, in0=8'hA0.., in1=8'hB0.., out_ready=1 ->
//    outputs A0,B0,A1,B1; sel toggles 0,1,0,1.
//  4 Stall: out_valid=1 holding 8'h55, out_ready=0 for 3 clks ->
//    out_data=55, sel unchanged, in*_ready=0; on release, the next word
//    follows one cycle after accept.
//  5 Pointer hold: in1 accepted (last_grant=1), then idle 5 clks, then both
//    valid -> in0 granted first.
//  6 Reset mid-stream: rst pulse during test 3 -> out_valid=0 next edge;
//    after release in0 wins the first tie.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - two-input round-robin arbiter with a one-entry registered output stage
module mux2_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic             last_grant
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_sel;
    logic             r_last_grant;

    logic             w_can_accept;
    logic             w_any_valid;
    logic             w_grant;
    logic             w_accept;
    logic [WIDTH-1:0] w_grant_data;

    // Ties go to the source that did not win last; a lone valid source always wins.
    assign w_can_accept = !r_out_valid || out_ready;
    assign w_any_valid  = in0_valid || in1_valid;
    assign w_grant      = (in0_valid && in1_valid) ? !r_last_grant : in1_valid;
    assign w_grant_data = w_grant ? in1_data : in0_data;

    assign in0_ready = w_can_accept && !rst && w_any_valid && !w_grant;
    assign in1_ready = w_can_accept && !rst && w_any_valid &&  w_grant;
    assign w_accept  = (in0_valid && in0_ready) || (in1_valid && in1_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_sel        <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= w_grant_data;
            r_sel        <= w_grant;
            r_last_grant <= w_grant;
        end else if (r_out_valid && out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign sel        = r_sel;
    assign last_grant = r_last_grant;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb/tb_mux2_rr_arbiter.sv - scoreboard bench for mux2_rr_arbiter with a queue-based reference model
module tb_mux2_rr_arbiter;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in0_valid, in1_valid, in0_ready, in1_ready;
    logic [W-1:0] in0_data, in1_data, out_data;
    logic         out_valid, out_ready, sel, last_grant;

    mux2_rr_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .sel(sel), .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic         s;
        logic [W-1:0] d;
    } exp_t;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    exp_t         exp_q[$];
    logic [W-1:0] out_log[$];

    // Reference state: is a word held downstream, who won last, what is on the output.
    bit           m_full = 1'b0;
    bit           m_ptr  = 1'b1;
    logic [W-1:0] m_data = '0;
    bit           m_sel  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit e0, input bit e1, input bit ordy, input bit r);
        @(posedge clk);
        #1;
        rst       = r;
        out_ready = ordy;
        in0_valid = e0 && (q0.size() > 0);
        in0_data  = (q0.size() > 0) ? q0[0] : '0;
        in1_valid = e1 && (q1.size() > 0);
        in1_data  = (q1.size() > 0) ? q1[0] : '0;
    endtask

    task automatic drain(input bit e0, input bit e1, input string name);
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cyc(e0, e1, 1'b1, 1'b0);
            @(negedge clk);
            #1;
            if (q0.size() == 0 && q1.size() == 0 && !m_full) begin
                done = 1'b1;
                break;
            end
        end
        chk({name, "_drain_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic chk_log(input string name, input logic [W-1:0] exp[$]);
        chk({name, "_count"}, 32'(out_log.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < out_log.size(); i++)
            chk({name, "_word"}, 32'(out_log[i]), 32'(exp[i]));
    endtask

    // Reference model: predicts readies from the arbitration rule and records accepted words.
    always @(negedge clk) begin
        bit v0, v1, can, r0, r1, g;
        exp_t e;
        if (rst) begin
            chk("rst_in0_ready", 32'(in0_ready), 32'd0);
            chk("rst_in1_ready", 32'(in1_ready), 32'd0);
            m_full = 1'b0;
            m_ptr  = 1'b1;
            m_data = '0;
            m_sel  = 1'b0;
            exp_q.delete();
        end else begin
            v0  = in0_valid;
            v1  = in1_valid;
            can = !m_full || out_ready;
            r0  = can && v0 && (!v1 || m_ptr == 1'b1);
            r1  = can && v1 && (!v0 || m_ptr == 1'b0);
            chk("out_valid", 32'(out_valid), 32'(m_full));
            chk("last_grant", 32'(last_grant), 32'(m_ptr));
            chk("out_data_hold", 32'(out_data), 32'(m_data));
            chk("sel_hold", 32'(sel), 32'(m_sel));
            chk("in0_ready", 32'(in0_ready), 32'(r0));
            chk("in1_ready", 32'(in1_ready), 32'(r1));
            if (r0 || r1) begin
                g   = r1;
                e.s = g;
                e.d = g ? q1.pop_front() : q0.pop_front();
                exp_q.push_back(e);
                m_ptr  = g;
                m_full = 1'b1;
                m_data = e.d;
                m_sel  = g;
            end else if (out_ready) begin
                m_full = 1'b0;
            end
        end
    end

    // Monitor: whenever the DUT presents a word, it must match the oldest expected one.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            chk("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                chk("sb_out_data", 32'(out_data), 32'(e.d));
                chk("sb_sel", 32'(sel), 32'(e.s));
                if (out_ready) begin
                    out_log.push_back(out_data);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [W-1:0] exp_words[$];
        rst = 1'b1; out_ready = 1'b0;
        in0_valid = 1'b0; in1_valid = 1'b0; in0_data = '0; in1_data = '0;

        // Reset with in0 already offering words: nothing may be accepted.
        q0 = '{8'h01, 8'h02, 8'h03, 8'h04};
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk); #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_last_grant", 32'(last_grant), 32'd1);
        chk("reset_in0_ready", 32'(in0_ready), 32'd0);

        // Single source streaming
        out_log.delete();
        drain(1'b1, 1'b0, "single");
        exp_words = '{8'h01, 8'h02, 8'h03, 8'h04};
        chk_log("single", exp_words);

        // Tie alternation from a fresh pointer
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        out_log.delete();
        q0 = '{8'hA0, 8'hA1};
        q1 = '{8'hB0, 8'hB1};
        drain(1'b1, 1'b1, "tie");
        exp_words = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
        chk_log("tie", exp_words);

        // Stall holding 8'h55
        out_log.delete();
        q0 = '{8'h55, 8'h66};
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            @(negedge clk); #1;
            chk("stall_out_data", 32'(out_data), 32'h55);
            chk("stall_in0_ready", 32'(in0_ready), 32'd0);
        end
        drain(1'b1, 1'b0, "stall");
        exp_words = '{8'h55, 8'h66};
        chk_log("stall", exp_words);

        // Pointer hold across idle cycles
        out_log.delete();
        q1 = '{8'h77};
        drain(1'b0, 1'b1, "ptr_in1");
        repeat (5) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk); #1;
        chk("idle_last_grant", 32'(last_grant), 32'd1);
        q0 = '{8'hC0};
        q1 = '{8'hD0};
        drain(1'b1, 1'b1, "ptr_tie");
        exp_words = '{8'h77, 8'hC0, 8'hD0};
        chk_log("ptr_hold", exp_words);

        // Reset in the middle of a tie stream
        q0 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        q1 = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk); #1;
        chk("midrst_last_grant", 32'(last_grant), 32'd1);
        out_log.delete();
        drain(1'b1, 1'b1, "midrst");
        chk("midrst_first_nonempty", 32'(out_log.size() != 0), 32'd1);
        if (out_log.size() != 0)
            chk("midrst_first_src", 32'(out_log[0][7:4]), 32'hA);

        // Random traffic, backpressure and occasional resets
        for (int i = 0; i < 400; i++) begin
            if (q0.size() < 3) q0.push_back(W'($urandom));
            if (q1.size() < 3) q1.push_back(W'($urandom));
            cyc(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 4) != 0,
                ($urandom % 64) == 0);
        end
        drain(1'b1, 1'b1, "random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
